// File: rtl/data_mem_responder_if.sv
// Request/response bus between a CPU memory stage (master) and the data
// memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Handshaked data memory: one request at a time, WAIT_STATES wait cycles,
// then a held response carrying load data or a store acknowledgement.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic [31:0]     r_rsp_rdata;
  logic            r_rsp_err;

  logic            r_write;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;

  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_enter_resp;
  logic            w_write;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic [3:0]      w_be;
  logic            w_err;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign w_accept = (r_state == S_IDLE) && r_req_ready && bus.req_valid;

  // With zero wait states the commit edge is the acceptance edge itself, so
  // the request fields are taken straight from the bus instead of the latches.
  assign w_enter_resp = ((r_state == S_WAIT) && (r_cnt == '0)) ||
                        (w_accept && (WAIT_STATES == 0));

  // Select live request fields in IDLE, latched fields otherwise
  always_comb begin
    w_write = r_write;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_be    = r_be;
    if (r_state == S_IDLE) begin
      w_write = bus.req_write;
      w_addr  = bus.req_addr;
      w_wdata = bus.req_wdata;
      w_be    = bus.req_be;
    end
  end

  assign w_err = (w_addr[1:0] != 2'b00) || ((w_addr >> (ADDR_WIDTH + 2)) != '0);
  assign w_idx = w_addr[ADDR_WIDTH+1:2];

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_write     <= bus.req_write;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_be        <= bus.req_be;
            if (WAIT_STATES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CW'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase

      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || w_write) ? '0 : r_mem[w_idx];
      end
    end
  end

  // Byte-masked store into the unreset array on the commit edge
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_write && !w_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_STATES=2 instance and a
// WAIT_STATES=0 instance sharing one clock and reset.
module tb_data_mem_responder;

  logic clk;
  logic rst;

  data_mem_responder_if a_if ();
  data_mem_responder_if b_if ();

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  // Shared drive signals; sel routes the request to instance B
  logic        sel;
  logic        drv_valid;
  logic        drv_write;
  logic [31:0] drv_addr;
  logic [31:0] drv_wdata;
  logic [3:0]  drv_be;
  logic        drv_rsp_ready;

  assign a_if.req_valid = drv_valid && !sel;
  assign a_if.req_write = drv_write;
  assign a_if.req_addr  = drv_addr;
  assign a_if.req_wdata = drv_wdata;
  assign a_if.req_be    = drv_be;
  assign a_if.rsp_ready = sel ? 1'b1 : drv_rsp_ready;

  assign b_if.req_valid = drv_valid && sel;
  assign b_if.req_write = drv_write;
  assign b_if.req_addr  = drv_addr;
  assign b_if.req_wdata = drv_wdata;
  assign b_if.req_be    = drv_be;
  assign b_if.rsp_ready = sel ? drv_rsp_ready : 1'b1;

  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  assign o_req_ready = sel ? b_if.req_ready : a_if.req_ready;
  assign o_rsp_valid = sel ? b_if.rsp_valid : a_if.rsp_valid;
  assign o_rsp_rdata = sel ? b_if.rsp_rdata : a_if.rsp_rdata;
  assign o_rsp_err   = sel ? b_if.rsp_err   : a_if.rsp_err;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request/response; lat_exp counts edges from acceptance to the first
  // edge that samples rsp_valid high. stall holds rsp_ready low that many
  // cycles and pulses a stray store request in the middle of the stall.
  task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int lat_exp, input int stall);
    int n;
    int k;
    drv_rsp_ready = (stall == 0);
    drv_write = wr;
    drv_addr  = addr;
    drv_wdata = wdata;
    drv_be    = be;
    drv_valid = 1'b1;
    n = 0;
    while (o_req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, 32'(o_req_ready), 32'd1);
    step();
    drv_valid = 1'b0;
    drv_wdata = 32'hA5A5_A5A5;
    drv_addr  = 32'h0000_0000;
    k = 1;
    while (o_rsp_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'(lat_exp));
    chk({tag, "_err"}, 32'(o_rsp_err), 32'(exp_err));
    chk({tag, "_rdata"}, o_rsp_rdata, exp_rdata);
    chk({tag, "_busy"}, 32'(o_req_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      if (i == 2) begin
        drv_write = 1'b1;
        drv_addr  = 32'h0000_0010;
        drv_wdata = 32'h0000_0000;
        drv_be    = 4'b1111;
        drv_valid = 1'b1;
      end
      step();
      drv_valid = 1'b0;
      chk({tag, "_hold_v"}, 32'(o_rsp_valid), 32'd1);
      chk({tag, "_hold_d"}, o_rsp_rdata, exp_rdata);
      chk({tag, "_hold_r"}, 32'(o_req_ready), 32'd0);
    end
    drv_rsp_ready = 1'b1;
    step();
    chk({tag, "_done_v"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, "_done_r"}, 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    sel           = 1'b0;
    drv_valid     = 1'b0;
    drv_write     = 1'b0;
    drv_addr      = '0;
    drv_wdata     = '0;
    drv_be        = '0;
    drv_rsp_ready = 1'b1;
    rst           = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready_a", 32'(a_if.req_ready), 32'd0);
      chk("rst_valid_a", 32'(a_if.rsp_valid), 32'd0);
      chk("rst_rdata_a", a_if.rsp_rdata, 32'd0);
    end
    chk("rst_err_a", 32'(a_if.rsp_err), 32'd0);
    chk("rst_ready_b", 32'(b_if.req_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_ready_pre", 32'(a_if.req_ready), 32'd0);
    step();
    chk("rel_ready_post", 32'(a_if.req_ready), 32'd1);
    chk("rel_ready_b", 32'(b_if.req_ready), 32'd1);

    // Store/load round trip, byte enables, errors on the WAIT_STATES=2 instance
    txn("st10",   1'b1, 32'h10,  32'hDEAD_BEEF, 4'b1111, 32'h0,          1'b0, 3, 0);
    txn("ld10",   1'b0, 32'h10,  32'h0,         4'b0000, 32'hDEAD_BEEF,  1'b0, 3, 0);
    txn("stbe",   1'b1, 32'h10,  32'h1122_3344, 4'b0101, 32'h0,          1'b0, 3, 0);
    txn("ldbe",   1'b0, 32'h10,  32'h0,         4'b0000, 32'hDE22_BE44,  1'b0, 3, 0);
    txn("ldmis",  1'b0, 32'h13,  32'h0,         4'b0000, 32'h0,          1'b1, 3, 0);
    txn("st00",   1'b1, 32'h0,   32'h0123_4567, 4'b1111, 32'h0,          1'b0, 3, 0);
    txn("stoor",  1'b1, 32'h400, 32'hFFFF_FFFF, 4'b1111, 32'h0,          1'b1, 3, 0);
    txn("ld00",   1'b0, 32'h0,   32'h0,         4'b0000, 32'h0123_4567,  1'b0, 3, 0);
    txn("stbe0",  1'b1, 32'h10,  32'hFFFF_FFFF, 4'b0000, 32'h0,          1'b0, 3, 0);
    txn("ldbe0",  1'b0, 32'h10,  32'h0,         4'b0000, 32'hDE22_BE44,  1'b0, 3, 0);

    // Back-pressure with a stray request during the stall
    txn("bp",     1'b0, 32'h10,  32'h0,         4'b0000, 32'hDE22_BE44,  1'b0, 3, 5);
    txn("ldpost", 1'b0, 32'h10,  32'h0,         4'b0000, 32'hDE22_BE44,  1'b0, 3, 0);

    // Reset during WAIT drops the uncommitted store
    txn("st20",   1'b1, 32'h20,  32'h55AA_55AA, 4'b1111, 32'h0,          1'b0, 3, 0);
    drv_write = 1'b1;
    drv_addr  = 32'h20;
    drv_wdata = 32'hCAFE_F00D;
    drv_be    = 4'b1111;
    drv_valid = 1'b1;
    chk("mw_ready", 32'(o_req_ready), 32'd1);
    step();
    drv_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("mw_ready_rst", 32'(a_if.req_ready), 32'd0);
    chk("mw_valid_rst", 32'(a_if.rsp_valid), 32'd0);
    chk("mw_rdata_rst", a_if.rsp_rdata, 32'd0);
    chk("mw_err_rst", 32'(a_if.rsp_err), 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("mw_ready_rel", 32'(a_if.req_ready), 32'd1);
    txn("ld20",   1'b0, 32'h20,  32'h0,         4'b0000, 32'h55AA_55AA,  1'b0, 3, 0);

    // WAIT_STATES=0 instance
    sel = 1'b1;
    txn("b_st44", 1'b1, 32'h44,  32'h0BAD_CAFE, 4'b1111, 32'h0,          1'b0, 1, 0);
    txn("b_ld44", 1'b0, 32'h44,  32'h0,         4'b0000, 32'h0BAD_CAFE,  1'b0, 1, 0);
    txn("b_oor",  1'b0, 32'h800, 32'h0,         4'b0000, 32'h0,          1'b1, 1, 0);
    sel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
